// File: rtl/uart_rx_arbiter.sv
// Round-robin arbiter that funnels NUM_CH UART receive channels into one
// valid/ready byte stream, with per-channel holding registers and overrun flags.
//
// state  | meaning
// EMPTY  | output register holds no byte (out_valid=0)
// LOADED | output register holds a byte waiting for the consumer (out_valid=1)
module uart_rx_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int DATA_W = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     en,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ovr_clr,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic [NUM_CH-1:0]        hold_full,
  output logic [NUM_CH-1:0]        ovr_flag
);

  typedef enum logic {EMPTY = 1'b0, LOADED = 1'b1} slot_e;

  slot_e             state_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CH_W-1:0]   out_ch_q;
  logic [CH_W-1:0]   rr_last_q;

  logic [NUM_CH-1:0] hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_data_q [NUM_CH];
  logic [DATA_W-1:0] hold_data_d [NUM_CH];
  logic [NUM_CH-1:0] ovr_q, ovr_d;

  logic              out_free;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_idx;
  logic [NUM_CH-1:0] drain;
  int                cand;

  // Walk the search order backwards so the last hit is the first full channel after rr_last.
  always_comb begin
    out_free  = (state_q == EMPTY) || out_ready;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    if (en && out_free) begin
      for (int off = NUM_CH; off >= 1; off--) begin
        cand = (int'(rr_last_q) + off) % NUM_CH;
        if (hold_full_q[cand]) begin
          grant_vld = 1'b1;
          grant_idx = CH_W'(cand);
        end
      end
    end
  end

  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    ovr_d       = ovr_q & ~ovr_clr;
    drain       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      drain[i] = grant_vld && (grant_idx == CH_W'(i));
      if (ch_valid[i]) begin
        if (!hold_full_q[i] || drain[i]) begin
          hold_data_d[i] = ch_data[i*DATA_W +: DATA_W];
          hold_full_d[i] = 1'b1;
        end else begin
          ovr_d[i] = 1'b1;
        end
      end else if (drain[i]) begin
        hold_full_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_full_q <= '0;
      ovr_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) hold_data_q[i] <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      ovr_q       <= ovr_d;
      hold_data_q <= hold_data_d;
    end
  end

  // A grant can only happen when the slot is free, so both states load on grant.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_ch_q   <= '0;
      rr_last_q  <= CH_W'(NUM_CH - 1);
    end else begin
      case (state_q)
        EMPTY: begin
          if (grant_vld) begin
            state_q    <= LOADED;
            out_data_q <= hold_data_q[grant_idx];
            out_ch_q   <= grant_idx;
            rr_last_q  <= grant_idx;
          end
        end
        LOADED: begin
          if (grant_vld) begin
            out_data_q <= hold_data_q[grant_idx];
            out_ch_q   <= grant_idx;
            rr_last_q  <= grant_idx;
          end else if (out_ready) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign out_valid = (state_q == LOADED);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign hold_full = hold_full_q;
  assign ovr_flag  = ovr_q;

endmodule

// File: tb/tb_uart_rx_arbiter.sv
// Self-checking bench for uart_rx_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a cycle-level reference model.
module tb_uart_rx_arbiter;
  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic         en;
  logic [N-1:0] ch_valid;
  logic [N*8-1:0] ch_data;
  logic [N-1:0] ovr_clr;
  logic         out_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic [1:0]   out_ch;
  logic [N-1:0] hold_full;
  logic [N-1:0] ovr_flag;

  int total = 0;
  int bad   = 0;

  uart_rx_arbiter #(.NUM_CH(N), .CH_W(2), .DATA_W(8)) dut (
    .CLK(CLK), .RST(RST), .en(en), .ch_valid(ch_valid), .ch_data(ch_data),
    .ovr_clr(ovr_clr), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch), .hold_full(hold_full), .ovr_flag(ovr_flag)
  );

  always #5 CLK = ~CLK;

  // Reference model: plain per-channel arrays and a round-robin search.
  logic       m_full [N];
  logic [7:0] m_hold [N];
  logic       m_ovr  [N];
  logic       m_ov;
  logic [7:0] m_od;
  int         m_oc, m_rr;
  logic       n_full [N];
  logic [7:0] n_hold [N];
  logic       n_ovr  [N];
  logic       n_ov;
  logic [7:0] n_od;
  int         n_oc, n_rr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] pack(input logic a [N]);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic model_calc();
    int g;
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        n_full[i] = 1'b0; n_hold[i] = 8'h00; n_ovr[i] = 1'b0;
      end
      n_ov = 1'b0; n_od = 8'h00; n_oc = 0; n_rr = N - 1;
      return;
    end
    n_full = m_full; n_hold = m_hold; n_ov = m_ov; n_od = m_od; n_oc = m_oc; n_rr = m_rr;
    g = -1;
    if (en && (!m_ov || out_ready)) begin
      for (int off = 1; off <= N; off++)
        if (g < 0 && m_full[(m_rr + off) % N]) g = (m_rr + off) % N;
    end
    if (g >= 0) begin
      n_ov = 1'b1; n_od = m_hold[g]; n_oc = g; n_rr = g;
    end else if (m_ov && out_ready) begin
      n_ov = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      logic set;
      set = 1'b0;
      if (ch_valid[i]) begin
        if (!m_full[i] || g == i) begin
          n_hold[i] = ch_data[i*8 +: 8];
          n_full[i] = 1'b1;
        end else begin
          set = 1'b1;
        end
      end else if (g == i) begin
        n_full[i] = 1'b0;
      end
      n_ovr[i] = set ? 1'b1 : (ovr_clr[i] ? 1'b0 : m_ovr[i]);
    end
  endtask

  task automatic model_chk();
    chk("mdl_out_valid", out_valid, m_ov);
    chk("mdl_hold_full", hold_full, pack(m_full));
    chk("mdl_ovr_flag", ovr_flag, pack(m_ovr));
    if (m_ov) begin
      chk("mdl_out_data", out_data, m_od);
      chk("mdl_out_ch", out_ch, m_oc);
    end
  endtask

  task automatic cyc();
    model_calc();
    @(posedge CLK);
    m_full = n_full; m_hold = n_hold; m_ovr = n_ovr;
    m_ov = n_ov; m_od = n_od; m_oc = n_oc; m_rr = n_rr;
    #1;
    model_chk();
  endtask

  task automatic drive(input logic e, input logic r, input logic [N-1:0] v,
                       input logic [31:0] d, input logic [N-1:0] c);
    en = e; out_ready = r; ch_valid = v; ch_data = d; ovr_clr = c;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    cyc();
    RST = 1'b0;
  endtask

  typedef struct {
    logic         rst, en, rdy;
    logic [N-1:0] vld;
    logic [31:0]  data;
    logic [N-1:0] clr;
    logic         ev;
    logic [7:0]   ed;
    logic [1:0]   ec;
    logic [N-1:0] ehf, eovr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic e, logic rdy, logic [N-1:0] vld, logic [31:0] data,
                              logic [N-1:0] clr, logic ev, logic [7:0] ed, logic [1:0] ec,
                              logic [N-1:0] ehf, logic [N-1:0] eovr);
    vec_t v;
    v.rst = rst; v.en = e; v.rdy = rdy; v.vld = vld; v.data = data; v.clr = clr;
    v.ev = ev; v.ed = ed; v.ec = ec; v.ehf = ehf; v.eovr = eovr;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      m_full[i] = 1'b0; m_hold[i] = 8'h00; m_ovr[i] = 1'b0;
    end
    m_ov = 1'b0; m_od = 8'h00; m_oc = 0; m_rr = N - 1;
    RST = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);

    // single byte on ch2
    tbl.push_back(mk(1, 0, 0, 4'b0000, 32'h0,        4'b0000, 0, 8'h00, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 1, 4'b0100, 32'h00A50000, 4'b0000, 0, 8'h00, 0, 4'b0100, 4'b0000));
    tbl.push_back(mk(0, 1, 1, 4'b0000, 32'h0,        4'b0000, 1, 8'hA5, 2, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 1, 4'b0000, 32'h0,        4'b0000, 0, 8'h00, 0, 4'b0000, 4'b0000));
    // fairness round, then a ch1-only grant followed by a full round
    tbl.push_back(mk(1, 1, 1, 4'b0000, 32'h0,        4'b0000, 0, 8'h00, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 1, 4'b1111, 32'h13121110, 4'b0000, 0, 8'h00, 0, 4'b1111, 4'b0000));
    tbl.push_back(mk(0, 1, 1, 4'b0000, 32'h0,        4'b0000, 1, 8'h10, 0, 4'b1110, 4'b0000));
    tbl.push_back(mk(0, 1, 1, 4'b0000, 32'h0,        4'b0000, 1, 8'h11, 1, 4'b1100, 4'b0000));
    tbl.push_back(mk(0, 1, 1, 4'b0000, 32'h0,        4'b0000, 1, 8'h12, 2, 4'b1000, 4'b0000));
    tbl.push_back(mk(0, 1, 1, 4'b0000, 32'h0,        4'b0000, 1, 8'h13, 3, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 1, 4'b0000, 32'h0,        4'b0000, 0, 8'h00, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 1, 4'b0010, 32'h00002100, 4'b0000, 0, 8'h00, 0, 4'b0010, 4'b0000));
    tbl.push_back(mk(0, 1, 1, 4'b1111, 32'h33323130, 4'b0000, 1, 8'h21, 1, 4'b1111, 4'b0000));
    tbl.push_back(mk(0, 1, 1, 4'b0000, 32'h0,        4'b0000, 1, 8'h32, 2, 4'b1011, 4'b0000));
    tbl.push_back(mk(0, 1, 1, 4'b0000, 32'h0,        4'b0000, 1, 8'h33, 3, 4'b0011, 4'b0000));
    tbl.push_back(mk(0, 1, 1, 4'b0000, 32'h0,        4'b0000, 1, 8'h30, 0, 4'b0010, 4'b0000));
    tbl.push_back(mk(0, 1, 1, 4'b0000, 32'h0,        4'b0000, 1, 8'h31, 1, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 1, 4'b0000, 32'h0,        4'b0000, 0, 8'h00, 0, 4'b0000, 4'b0000));
    // backpressure and overrun on ch0
    tbl.push_back(mk(1, 1, 0, 4'b0000, 32'h0,        4'b0000, 0, 8'h00, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 4'b0001, 32'h00000001, 4'b0000, 0, 8'h00, 0, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 4'b0000, 32'h0,        4'b0000, 1, 8'h01, 0, 4'b0000, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 4'b0001, 32'h00000002, 4'b0000, 1, 8'h01, 0, 4'b0001, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 4'b0001, 32'h00000003, 4'b0000, 1, 8'h01, 0, 4'b0001, 4'b0001));
    tbl.push_back(mk(0, 1, 1, 4'b0000, 32'h0,        4'b0000, 1, 8'h02, 0, 4'b0000, 4'b0001));
    tbl.push_back(mk(0, 1, 1, 4'b0000, 32'h0,        4'b0000, 0, 8'h00, 0, 4'b0000, 4'b0001));
    tbl.push_back(mk(0, 1, 1, 4'b0000, 32'h0,        4'b0001, 0, 8'h00, 0, 4'b0000, 4'b0000));

    for (int r = 0; r < tbl.size(); r++) begin
      RST = tbl[r].rst;
      drive(tbl[r].en, tbl[r].rdy, tbl[r].vld, tbl[r].data, tbl[r].clr);
      cyc();
      chk($sformatf("vec%0d_out_valid", r), out_valid, tbl[r].ev);
      chk($sformatf("vec%0d_hold_full", r), hold_full, tbl[r].ehf);
      chk($sformatf("vec%0d_ovr_flag", r), ovr_flag, tbl[r].eovr);
      if (tbl[r].ev) begin
        chk($sformatf("vec%0d_out_data", r), out_data, tbl[r].ed);
        chk($sformatf("vec%0d_out_ch", r), out_ch, tbl[r].ec);
      end
    end

    // drain-and-refill on ch1
    do_reset();
    drive(1, 1, 4'b0010, 32'h00005500, 4'b0000); cyc();
    chk("dr_hold_full0", hold_full, 4'b0010);
    drive(1, 1, 4'b0010, 32'h00007E00, 4'b0000); cyc();
    chk("dr_out_data0", out_data, 8'h55);
    chk("dr_hold_full1", hold_full, 4'b0010);
    chk("dr_ovr", ovr_flag, 4'b0000);
    drive(1, 1, 4'b0000, 32'h0, 4'b0000); cyc();
    chk("dr_out_valid", out_valid, 1'b1);
    chk("dr_out_data1", out_data, 8'h7E);
    chk("dr_out_ch1", out_ch, 2'd1);

    // overrun set beats clear on ch3
    do_reset();
    drive(0, 0, 4'b1000, 32'hAA000000, 4'b0000); cyc();
    drive(0, 0, 4'b1000, 32'hBB000000, 4'b1000); cyc();
    chk("clr_set_wins", ovr_flag, 4'b1000);
    drive(0, 0, 4'b0000, 32'h0, 4'b1000); cyc();
    chk("clr_alone", ovr_flag, 4'b0000);
    drive(1, 1, 4'b0000, 32'h0, 4'b0000); cyc();
    chk("clr_held_byte", out_data, 8'hAA);
    chk("clr_held_ch", out_ch, 2'd3);

    // en=0 blocks grants; reset while loaded
    do_reset();
    drive(1, 0, 4'b0001, 32'h00000001, 4'b0000); cyc();
    drive(1, 0, 4'b0000, 32'h0, 4'b0000); cyc();
    drive(0, 0, 4'b1111, 32'h44434241, 4'b0000); cyc();
    chk("en0_hold_full", hold_full, 4'b1111);
    drive(0, 1, 4'b0000, 32'h0, 4'b0000); cyc();
    chk("en0_accept", out_valid, 1'b0);
    cyc();
    chk("en0_no_grant", out_valid, 1'b0);
    drive(1, 0, 4'b0000, 32'h0, 4'b0000); cyc();
    chk("en1_next_ch", out_ch, 2'd1);
    chk("en1_next_data", out_data, 8'h42);
    RST = 1'b1;
    drive(1, 1, 4'b0000, 32'h0, 4'b0000); cyc();
    RST = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_ch", out_ch, 2'd0);
    chk("rst_hold_full", hold_full, 4'b0000);
    chk("rst_ovr", ovr_flag, 4'b0000);
    drive(1, 1, 4'b1111, 32'h13121110, 4'b0000); cyc();
    drive(1, 1, 4'b0000, 32'h0, 4'b0000); cyc();
    chk("rst_rr_first_ch", out_ch, 2'd0);
    chk("rst_rr_first_data", out_data, 8'h10);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom_range(0, 199) == 0);
      drive(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
            N'($urandom & $urandom), $urandom,
            ($urandom_range(0, 7) == 0) ? N'($urandom) : '0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_arbiter.md
Name: uart_rx_arbiter

Overview:
- Shares one downstream byte consumer between NUM_CH UART receive channels.
- Each channel's data_valid pulse and 8-bit P_DAta byte are captured into a per-channel holding register.
- Full holding registers are granted round-robin into a single output register.
- The output register drives a valid/ready interface to the consumer, and an overrun is flagged per channel when a byte arrives while that channel's holding register is still full.

Parameters:
- NUM_CH, 4, number of receive channels; legal range 2..8.
- CH_W, 2, width of the channel index; must equal clog2(NUM_CH).
- DATA_W, 8, byte width; fixed at 8.

Ports:
- CLK  in  1  single clock for all logic.
- RST  in  1  synchronous reset, active-high.
- en  in  1  arbitration enable; low blocks new grants.
- ch_valid  in  NUM_CH  one-cycle data_valid pulse per channel.
- ch_data  in  NUM_CH*DATA_W  byte per channel; channel i occupies bits [i*8+7:i*8].
- ovr_clr  in  NUM_CH  per-channel overrun flag clear, level-sampled.
- out_ready  in  1  consumer accepts the byte this cycle.
- out_valid  out  1  output byte present.
- out_data  out  DATA_W  output byte.
- out_ch  out  CH_W  channel index of out_data.
- hold_full  out  NUM_CH  holding register status per channel.
- ovr_flag  out  NUM_CH  sticky overrun flags.

Behaviour:
- Reset (RST=1 on a rising CLK edge):
  - out_valid=0, out_data=0, out_ch=0, hold_full=0, ovr_flag=0.
  - Round-robin pointer rr_last=NUM_CH-1, so channel 0 has first priority.
  - Holding data registers are cleared to 0.
  - Reset mid-transfer discards all held and output bytes.
- Capture, per channel i, every cycle:
  - drain_i=1 when channel i is granted this cycle.
  - ch_valid[i]=1 and (hold_full[i]=0 or drain_i=1): store ch_data byte i; hold_full[i]=1 next cycle.
  - ch_valid[i]=1, hold_full[i]=1 and drain_i=0: new byte discarded, held byte kept, ovr_flag[i]=1 next cycle.
  - drain_i=1 with no ch_valid[i]: hold_full[i]=0 next cycle.
- Overrun flags:
  - ovr_flag[i] clears when ovr_clr[i]=1.
  - A set and a clear in the same cycle: set wins.
- Output slot: out_free = !out_valid or (out_valid and out_ready).
- Grant:
  - Occurs when en=1, out_free=1 and any hold_full=1.
  - Search order starts at rr_last+1 and wraps modulo NUM_CH.
  - The first full channel k is granted: next cycle out_data=hold byte k, out_ch=k, out_valid=1, rr_last=k.
  - At most one grant per cycle.
- No grant but out_valid and out_ready: out_valid=0 next cycle.
- out_valid=1 and out_ready=0:
  - out_data and out_ch hold stable.
  - Holding registers keep filling.
- en=0:
  - No grants.
  - The current output byte can still be consumed.
  - Capture and overrun detection continue.
- Latency:
  - ch_valid at cycle t gives hold_full at t+1.
  - out_valid at t+2 if the slot is free and the channel wins arbitration.
- Throughput: one byte per cycle with out_ready held high (back-to-back grants).
- Fairness: each full channel is granted within NUM_CH grants.
- The controller is a two-state machine per output slot (EMPTY and LOADED), encoded by out_valid:
  - EMPTY to LOADED on grant.
  - LOADED to LOADED on accept plus grant.
  - LOADED to EMPTY on accept with no grant.
  - LOADED self-loops on a stall.

Test Plan:
- Reset then a single byte: ch_valid[2]=1, ch_data byte2=8'hA5 at t.
  - Required: hold_full[2]=1 at t+1.
  - Required: out_valid=1, out_data=8'hA5, out_ch=2 at t+2.
  - With out_ready=1: out_valid=0 at t+3.
- Fairness: all 4 channels pulse in the same cycle with bytes 8'h10, 8'h11, 8'h12, 8'h13, out_ready=1.
  - Required: outputs on consecutive cycles with ch order 0,1,2,3.
  - A second round after a ch1-only grant starts the search at ch2.
- Backpressure/overrun: out_ready=0, ch0 gets 8'h01 then later 8'h02.
  - Required: out_data stays 8'h01 and ovr_flag[0]=0.
  - A third byte 8'h03 while hold holds 8'h02: ovr_flag[0]=1, hold keeps 8'h02, and 8'h03 is never output.
- Drain-and-refill: ch1 granted in the same cycle a new ch_valid[1] with 8'h7E arrives.
  - Required: no overrun, hold_full[1] stays 1, and 8'h7E is output next.
- Flag clear priority: ovr_clr[3]=1 in the same cycle as a ch3 overrun.
  - Required: ovr_flag[3]=1.
  - ovr_clr[3]=1 alone then gives ovr_flag[3]=0.
- en=0 and reset mid-operation: with en=0 and hold_full=4'b1111, no new out_valid while the existing output is accepted.
  - Asserting RST while loaded: all outputs and flags are 0 next cycle, and rr_last=3.
